// File: rtl/sha3_pkg.sv
// Shared SHA3 types and helpers for the sponge datapath.
package sha3_pkg;

    localparam int unsigned X_AXIS_DEF = 5;
    localparam int unsigned Y_AXIS_DEF = 5;
    localparam int unsigned Z_AXIS_DEF = 64;

    typedef logic [Z_AXIS_DEF-1:0] lane_t;
    // Packed so that st_data[x][y] selects lane (x, y) directly
    typedef lane_t [X_AXIS_DEF-1:0][Y_AXIS_DEF-1:0] state_t;

    typedef enum logic [0:0] {
        SqIdle,
        SqSend
    } sq_state_e;

    function automatic int unsigned mod5(input int unsigned v);
        return v % 5;
    endfunction

    function automatic int unsigned mod64(input int unsigned v);
        return v % 64;
    endfunction

endpackage

// File: rtl/sha3_lane_bswap.sv
// Combinational byte reversal of one lane; a plain pass-through when disabled.
module sha3_lane_bswap #(
    parameter int unsigned Z_AXIS    = 64,
    parameter bit          BYTE_SWAP = 1'b0
) (
    input  logic [Z_AXIS-1:0] lane_i,
    output logic [Z_AXIS-1:0] lane_o
);

    if (BYTE_SWAP) begin : g_swap
        for (genvar b = 0; b < Z_AXIS / 8; b++) begin : g_byte
            assign lane_o[8*b +: 8] = lane_i[Z_AXIS-8-8*b +: 8];
        end
    end else begin : g_pass
        assign lane_o = lane_i;
    end

endmodule

// File: rtl/sha3_squeeze_tx.sv
// Squeeze end of the SHA3 sponge: captures a permuted state and streams the
// first DIGEST_LANES lanes out one per beat under valid/ready flow control.
module sha3_squeeze_tx
    import sha3_pkg::*;
#(
    parameter int unsigned X_AXIS       = X_AXIS_DEF,
    parameter int unsigned Y_AXIS       = Y_AXIS_DEF,
    parameter int unsigned Z_AXIS       = Z_AXIS_DEF,
    parameter int unsigned DIGEST_LANES = 4,
    parameter bit          BYTE_SWAP    = 1'b0
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          st_valid,
    output logic                                          st_ready,
    input  logic [X_AXIS-1:0][Y_AXIS-1:0][Z_AXIS-1:0]     st_data,
    output logic                                          dout_valid,
    input  logic                                          dout_ready,
    output logic [Z_AXIS-1:0]                             dout_data,
    output logic                                          dout_last,
    output logic                                          busy
);

    localparam int unsigned    CW       = $clog2(DIGEST_LANES + 1);
    localparam int unsigned    IW       = (DIGEST_LANES > 1) ? $clog2(DIGEST_LANES) : 1;
    localparam logic [CW-1:0]  LAST_CNT = CW'(DIGEST_LANES - 1);

    sq_state_e         state_q;
    logic [CW-1:0]     cnt_q;
    logic [Z_AXIS-1:0] lane_q   [DIGEST_LANES];
    logic [Z_AXIS-1:0] cap_lane [DIGEST_LANES];
    logic [IW-1:0]     next_idx;
    logic [Z_AXIS-1:0] next_lane;
    logic [Z_AXIS-1:0] next_out;
    logic              st_hs;

    // FIPS 202 lane order: lane i lives at x = i mod X_AXIS, y = i / X_AXIS
    for (genvar g = 0; g < DIGEST_LANES; g++) begin : g_cap
        assign cap_lane[g] = st_data[g % X_AXIS][g / X_AXIS];
    end

    assign st_hs = rst_n && st_valid && st_ready && (state_q == SqIdle);

    // Select the lane that will be on dout_data after the next advancing edge
    always_comb begin
        next_idx = '0;
        if (state_q == SqSend && cnt_q != LAST_CNT) begin
            next_idx = IW'(cnt_q) + IW'(1);
        end
        next_lane = (state_q == SqIdle) ? st_data[0][0] : lane_q[next_idx];
    end

    sha3_lane_bswap #(
        .Z_AXIS    (Z_AXIS),
        .BYTE_SWAP (BYTE_SWAP)
    ) u_bswap (
        .lane_i (next_lane),
        .lane_o (next_out)
    );

    // Lane buffer: loaded on capture only, intentionally left out of reset
    always_ff @(posedge clk) begin
        if (st_hs) begin
            lane_q <= cap_lane;
        end
    end

    // Squeeze FSM with registered handshake and digest outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= SqIdle;
            st_ready   <= 1'b0;
            dout_valid <= 1'b0;
            dout_data  <= '0;
            dout_last  <= 1'b0;
            busy       <= 1'b0;
            cnt_q      <= '0;
        end else begin
            unique case (state_q)
                SqIdle: begin
                    st_ready <= 1'b1;
                    if (st_valid && st_ready) begin
                        state_q    <= SqSend;
                        st_ready   <= 1'b0;
                        busy       <= 1'b1;
                        cnt_q      <= '0;
                        dout_valid <= 1'b1;
                        dout_data  <= next_out;
                        dout_last  <= (DIGEST_LANES == 1);
                    end
                end
                SqSend: begin
                    if (dout_ready) begin
                        if (cnt_q == LAST_CNT) begin
                            state_q    <= SqIdle;
                            dout_valid <= 1'b0;
                            dout_last  <= 1'b0;
                            busy       <= 1'b0;
                            st_ready   <= 1'b1;
                        end else begin
                            cnt_q     <= cnt_q + CW'(1);
                            dout_data <= next_out;
                            dout_last <= ((cnt_q + CW'(1)) == LAST_CNT);
                        end
                    end
                end
                default: state_q <= SqIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sha3_squeeze_tx.sv
// Scoreboard bench: DUT a is SHA3-256 (4 lanes, no swap), DUT b is 8 lanes with byte swap.
module tb_sha3_squeeze_tx;
    import sha3_pkg::*;

    typedef struct packed {
        lane_t data;
        logic  last;
    } beat_t;

    logic   clk = 1'b0;
    logic   rst_n;

    logic   a_st_valid, a_st_ready, a_dout_valid, a_dout_ready, a_dout_last, a_busy;
    state_t a_st_data;
    lane_t  a_dout_data;
    logic   b_st_valid, b_st_ready, b_dout_valid, b_dout_ready, b_dout_last, b_busy;
    state_t b_st_data;
    lane_t  b_dout_data;

    int     n_tests = 0;
    int     n_fail  = 0;
    beat_t  q_a[$];
    beat_t  q_b[$];
    bit     last_hs[2];
    int     hs_cnt[2];
    bit     rand_rdy = 1'b0;
    bit     rdy_pat[$];

    always #5 clk = ~clk;

    sha3_squeeze_tx #(.DIGEST_LANES(4), .BYTE_SWAP(1'b0)) u_dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .st_valid   (a_st_valid),
        .st_ready   (a_st_ready),
        .st_data    (a_st_data),
        .dout_valid (a_dout_valid),
        .dout_ready (a_dout_ready),
        .dout_data  (a_dout_data),
        .dout_last  (a_dout_last),
        .busy       (a_busy)
    );

    sha3_squeeze_tx #(.DIGEST_LANES(8), .BYTE_SWAP(1'b1)) u_dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .st_valid   (b_st_valid),
        .st_ready   (b_st_ready),
        .st_data    (b_st_data),
        .dout_valid (b_dout_valid),
        .dout_ready (b_dout_ready),
        .dout_data  (b_dout_data),
        .dout_last  (b_dout_last),
        .busy       (b_busy)
    );

    // Reference: digest lane i is A[i mod 5][i div 5], optionally byte-reversed
    function automatic lane_t model_lane(input state_t s, input int i, input bit bs);
        lane_t l;
        lane_t r;
        l = s[i % 5][i / 5];
        r = {<<8{l}};
        return bs ? r : l;
    endfunction

    function automatic state_t counting_state();
        state_t s;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                s[x][y] = lane_t'(16 * y + x + 1);
        return s;
    endfunction

    function automatic state_t random_state();
        state_t s;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                s[x][y] = {$urandom, $urandom};
        return s;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int q_size(input int w);
        return (w == 0) ? q_a.size() : q_b.size();
    endfunction

    task automatic q_push(input int w, input beat_t b);
        if (w == 0) q_a.push_back(b);
        else q_b.push_back(b);
    endtask

    task automatic q_pop(input int w, output beat_t b);
        if (w == 0) b = q_a.pop_front();
        else b = q_b.pop_front();
    endtask

    task automatic q_front(input int w, output beat_t b);
        if (w == 0) b = q_a[0];
        else b = q_b[0];
    endtask

    // One monitor sample: compares presented beat with the scoreboard head
    task automatic mon_step(input int w, input string tag, input logic v, input logic r,
                            input logic lst, input logic bsy, input logic sr, input lane_t d);
        beat_t b;
        if (last_hs[w]) begin
            check({tag, "_st_ready_after_last"}, sr, 1'b1);
            check({tag, "_valid_after_last"}, v, 1'b0);
        end
        last_hs[w] = 1'b0;
        if (v) begin
            if (q_size(w) == 0) begin
                check({tag, "_spurious_beat"}, v, 1'b0);
            end else begin
                q_front(w, b);
                check({tag, "_data"}, d, b.data);
                check({tag, "_last"}, lst, b.last);
                check({tag, "_busy"}, bsy, 1'b1);
                check({tag, "_st_ready_busy"}, sr, 1'b0);
                if (r) begin
                    last_hs[w] = b.last;
                    q_pop(w, b);
                    hs_cnt[w]++;
                end
            end
        end else if (q_size(w) != 0) begin
            check({tag, "_valid_gap"}, v, 1'b1);
        end else begin
            check({tag, "_busy_idle"}, bsy, 1'b0);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            mon_step(0, "a", a_dout_valid, a_dout_ready, a_dout_last, a_busy, a_st_ready,
                     a_dout_data);
            mon_step(1, "b", b_dout_valid, b_dout_ready, b_dout_last, b_busy, b_st_ready,
                     b_dout_data);
        end
    end

    // Sink ready drivers: pattern (consumed only while a beat is offered), random, or always 1
    initial begin
        a_dout_ready = 1'b0;
        b_dout_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (a_dout_valid && rdy_pat.size() > 0) a_dout_ready = rdy_pat.pop_front();
            else if (rand_rdy) a_dout_ready = 1'($urandom_range(0, 1));
            else a_dout_ready = 1'b1;
            b_dout_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Offer a state; on the capture edge push the expected digest beats
    task automatic load(input int w, input state_t s);
        int t;
        bit hs;
        int dl;
        t  = 0;
        hs = 1'b0;
        dl = (w == 0) ? 4 : 8;
        if (w == 0) begin a_st_data = s; a_st_valid = 1'b1; end
        else begin b_st_data = s; b_st_valid = 1'b1; end
        while (!hs && t < 300) begin
            @(negedge clk);
            hs = (w == 0) ? a_st_ready : b_st_ready;
            @(posedge clk);
            t++;
        end
        if (!hs) check((w == 0) ? "a_load_timeout" : "b_load_timeout", 64'(hs), 64'(1));
        else for (int i = 0; i < dl; i++) q_push(w, '{model_lane(s, i, w == 1), i == dl - 1});
        #1;
        // Scramble the bus so a late or repeated capture shows up as bad data
        if (w == 0) begin a_st_valid = 1'b0; a_st_data = random_state(); end
        else begin b_st_valid = 1'b0; b_st_data = random_state(); end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && t < 1000) begin
            @(posedge clk);
            t++;
        end
        check("drain_a_timeout", 64'(q_a.size()), 64'(0));
        check("drain_b_timeout", 64'(q_b.size()), 64'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_a_st_ready"}, a_st_ready, 1'b0);
        check({tag, "_a_dout_valid"}, a_dout_valid, 1'b0);
        check({tag, "_a_dout_data"}, a_dout_data, 64'h0);
        check({tag, "_a_dout_last"}, a_dout_last, 1'b0);
        check({tag, "_a_busy"}, a_busy, 1'b0);
        check({tag, "_b_st_ready"}, b_st_ready, 1'b0);
        check({tag, "_b_dout_valid"}, b_dout_valid, 1'b0);
        check({tag, "_b_busy"}, b_busy, 1'b0);
    endtask

    initial begin
        state_t s;
        int     base;
        int     t;
        rst_n      = 1'b0;
        a_st_valid = 1'b0;
        b_st_valid = 1'b0;
        a_st_data  = '0;
        b_st_data  = '0;
        hs_cnt[0]  = 0;
        hs_cnt[1]  = 0;
        last_hs[0] = 1'b0;
        last_hs[1] = 1'b0;

        // Reset held for 3 edges, then st_ready rises on the first released edge
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_release_a_st_ready_low", a_st_ready, 1'b0);
        @(negedge clk);
        check("first_cycle_a_st_ready", a_st_ready, 1'b1);
        check("first_cycle_b_st_ready", b_st_ready, 1'b1);
        @(posedge clk);
        #1;

        // Basic digests on both instances, sink always ready
        load(0, counting_state());
        s = counting_state();
        s[0][0] = 64'h0123456789abcdef;
        load(1, s);
        drain();

        // Backpressure pattern on a
        rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        load(0, counting_state());
        drain();

        // Busy reject: second state offered while the first digest is still streaming
        rdy_pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        load(0, counting_state());
        load(0, random_state());
        drain();

        // Mid-digest reset after beat 2 of a
        load(0, random_state());
        base = hs_cnt[0];
        t    = 0;
        while (hs_cnt[0] < base + 2 && t < 100) begin
            @(posedge clk);
            t++;
        end
        check("midreset_two_beats_seen", 64'(hs_cnt[0] - base), 64'(2));
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midreset_a_dout_valid", a_dout_valid, 1'b0);
        check("midreset_a_dout_last", a_dout_last, 1'b0);
        check("midreset_a_busy", a_busy, 1'b0);
        check("midreset_a_st_ready", a_st_ready, 1'b0);
        q_a.delete();
        q_b.delete();
        last_hs[0] = 1'b0;
        last_hs[1] = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        load(0, random_state());
        drain();

        // Randomized traffic on both instances with random sink stalls
        rand_rdy = 1'b1;
        for (int n = 0; n < 15; n++) begin
            load(0, random_state());
            load(1, random_state());
        end
        drain();
        rand_rdy = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
